shared_port_arbiter: RTL and testbench

//   Round-robin arbiter sharing one SIZE-bit downstream port between two requesters.

---
 rtl/shared_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_shared_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter sharing one SIZE-bit output register between two requesters.
// Grant is locked for a whole burst until the grantee's last beat is accepted.
module shared_port_arbiter #(
    parameter int unsigned SIZE = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      req_valid,
    input  logic [SIZE-1:0] req_data [2],
    input  logic [1:0]      req_last,
    output logic [1:0]      req_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            port,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic            port_q, port_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [SIZE-1:0] out_data_q, out_data_d;
    logic [SIZE-1:0] sel_data_c;
    logic            sel_last_c;
    logic            can_load_c;
    logic            accept_c;

    // Beat selection follows the current/most recent grantee.
    mux2x1 #(.SIZE(SIZE)) u_data_mux (
        .in0   (req_data[0]),
        .in1   (req_data[1]),
        .sel   (port_q),
        .out_c (sel_data_c)
    );

    mux2x1 #(.SIZE(1)) u_last_mux (
        .in0   (req_last[0]),
        .in1   (req_last[1]),
        .sel   (port_q),
        .out_c (sel_last_c)
    );

    // Handshake, next-state and output-register load logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        port_d      = port_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        req_ready   = 2'b00;

        can_load_c = !out_valid_q || out_ready;
        if (state_q == GRANT0) begin
            req_ready[0] = can_load_c;
        end
        if (state_q == GRANT1) begin
            req_ready[1] = can_load_c;
        end
        accept_c = |(req_valid & req_ready);

        case (state_q)
            IDLE: begin
                if (req_valid == 2'b11) begin
                    state_d = rr_ptr_q ? GRANT1 : GRANT0;
                    port_d  = rr_ptr_q;
                end else if (req_valid[0]) begin
                    state_d = GRANT0;
                    port_d  = 1'b0;
                end else if (req_valid[1]) begin
                    state_d = GRANT1;
                    port_d  = 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                // port_q always names the grantee while in a grant state.
                if (accept_c && sel_last_c) begin
                    state_d  = IDLE;
                    rr_ptr_d = ~port_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_c;
            out_last_d  = sel_last_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            port_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            port_q      <= port_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign port      = port_q;
    assign busy      = (state_q != IDLE);

endmodule

// Plain 2:1 data multiplexer.
module mux2x1 #(
    parameter int unsigned SIZE = 64
) (
    input  logic [SIZE-1:0] in0,
    input  logic [SIZE-1:0] in1,
    input  logic            sel,
    output logic [SIZE-1:0] out_c
);

    assign out_c = sel ? in1 : in0;

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Scoreboard bench for shared_port_arbiter: directed scenarios plus randomized
// bursts, checked against a transaction-level grant/output-register model.
module tb_shared_port_arbiter;

    localparam int unsigned SIZE = 64;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      req_valid;
    logic [SIZE-1:0] req_data [2];
    logic [1:0]      req_last;
    logic [1:0]      req_ready;
    logic            out_valid;
    logic [SIZE-1:0] out_data;
    logic            out_last;
    logic            out_ready;
    logic            port;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    shared_port_arbiter #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .port      (port),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = nobody), preference, and a one-deep output slot.
    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    int          m_owner = -1;
    logic        m_rr    = 1'b0;
    logic        m_port  = 1'b0;
    logic        m_ov    = 1'b0;
    logic [1:0]  m_acc   = 2'b00;

    always @(posedge clk or negedge reset_n) begin : model
        logic acc;
        logic own;
        if (!reset_n) begin
            m_owner <= -1;
            m_rr    <= 1'b0;
            m_port  <= 1'b0;
            m_ov    <= 1'b0;
            m_acc   <= 2'b00;
            exp_q.delete();
        end else begin
            own = m_owner[0];
            acc = (m_owner >= 0) && req_valid[own] && (!m_ov || out_ready);
            m_acc <= acc ? (2'b01 << own) : 2'b00;
            if (acc) begin
                m_ov <= 1'b1;
                exp_q.push_back('{req_data[own], req_last[own]});
            end else if (out_ready) begin
                m_ov <= 1'b0;
            end
            if (m_owner < 0) begin
                if (req_valid == 2'b11) begin
                    m_owner <= int'(m_rr);
                    m_port  <= m_rr;
                end else if (req_valid[0]) begin
                    m_owner <= 0;
                    m_port  <= 1'b0;
                end else if (req_valid[1]) begin
                    m_owner <= 1;
                    m_port  <= 1'b1;
                end
            end else if (acc && req_last[own]) begin
                m_owner <= -1;
                m_rr    <= ~own;
            end
        end
    end

    // Monitor: control outputs against the model; output beats against the scoreboard.
    always @(negedge clk) begin : monitor
        logic [1:0] er;
        if (reset_n) begin
            er = ((m_owner >= 0) && (!m_ov || out_ready)) ? (2'b01 << m_owner[0]) : 2'b00;
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("busy", 64'(busy), 64'(m_owner >= 0));
            chk("port", 64'(port), 64'(m_port));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            if (out_valid) begin
                chk("sb_has_beat", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("sb_out_data", out_data, exp_q[0].d);
                    chk("sb_out_last", 64'(out_last), 64'(exp_q[0].l));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid   = 2'b00;
        req_last    = 2'b00;
        req_data[0] = '0;
        req_data[1] = '0;
        out_ready   = 1'b0;
        reset_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int rem [2];
    int beat;
    int n;
    bit done;

    initial begin
        // Idle after reset.
        do_reset();
        repeat (5) step();
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_out_data", out_data, 64'd0);
        chk("idle_out_last", 64'(out_last), 64'd0);
        chk("idle_port", 64'(port), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_req_ready", 64'(req_ready), 64'd0);

        // Single beat latency.
        req_valid   = 2'b01;
        req_data[0] = 64'hA5;
        req_last    = 2'b01;
        out_ready   = 1'b1;
        step();
        chk("lat_busy_c1", 64'(busy), 64'd1);
        chk("lat_ready_c1", 64'(req_ready), 64'd1);
        chk("lat_out_valid_c1", 64'(out_valid), 64'd0);
        step();
        req_valid = 2'b00;
        chk("lat_out_valid_c2", 64'(out_valid), 64'd1);
        chk("lat_out_data_c2", out_data, 64'hA5);
        chk("lat_busy_c2", 64'(busy), 64'd0);
        step();

        // Round-robin alternation with both requesters always valid.
        do_reset();
        req_valid   = 2'b11;
        req_data[0] = 64'h10;
        req_data[1] = 64'h20;
        req_last    = 2'b11;
        out_ready   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            repeat (2) step();
            chk("rr_out_data", out_data, (k == 1) ? 64'h20 : 64'h10);
            chk("rr_port", 64'(port), 64'(k == 1));
        end
        req_valid = 2'b00;
        step();

        // Locked 3-beat burst from requester 0 with a 4-cycle downstream stall.
        do_reset();
        beat        = 1;
        done        = 1'b0;
        req_valid   = 2'b11;
        req_data[0] = 64'h1;
        req_last    = 2'b10;
        req_data[1] = 64'h99;
        out_ready   = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (m_acc[0]) begin
                beat++;
                if (beat > 3) begin
                    req_valid[0] = 1'b0;
                end else begin
                    req_data[0] = 64'(beat);
                    req_last[0] = (beat == 3);
                end
            end
            if (m_acc[1]) begin
                req_valid[1] = 1'b0;
                done = 1'b1;
            end
            out_ready = !(c >= 2 && c < 6);
        end
        chk("burst_done", 64'(done), 64'd1);
        out_ready = 1'b1;
        repeat (2) step();

        // Asynchronous reset while beat 2 of a burst sits in the output register.
        do_reset();
        req_valid   = 2'b01;
        req_last    = 2'b00;
        req_data[0] = 64'h11;
        out_ready   = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            step();
            if (m_acc[0]) begin
                n++;
                req_data[0] = (n == 1) ? 64'h22 : 64'h33;
            end
        end
        chk("areset_setup", 64'(n), 64'd2);
        chk("areset_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_out_data", out_data, 64'd0);
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_req_ready", 64'(req_ready), 64'd0);
        chk("areset_port", 64'(port), 64'd0);
        req_valid = 2'b00;
        #3;
        reset_n = 1'b1;
        step();
        req_valid   = 2'b01;
        req_data[0] = 64'h77;
        req_last    = 2'b01;
        step();
        chk("post_reset_busy", 64'(busy), 64'd1);
        step();
        req_valid = 2'b00;
        chk("post_reset_out_valid", 64'(out_valid), 64'd1);
        chk("post_reset_out_data", out_data, 64'h77);
        step();

        // Randomized bursts, valid drops and backpressure.
        do_reset();
        rem[0] = 0;
        rem[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i] && rem[i] > 0) begin
                    rem[i]--;
                end
                if (rem[i] == 0 && ($urandom % 3) == 0) begin
                    rem[i] = 1 + int'($urandom % 4);
                end
                req_valid[i] = (rem[i] > 0) && (($urandom % 5) != 0);
                req_data[i]  = {$urandom, $urandom};
                req_last[i]  = (rem[i] == 1);
            end
            out_ready = (($urandom % 4) != 0);
        end
        req_valid = 2'b00;
        out_ready = 1'b1;
        repeat (10) step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
